// File: rtl/cpu_stage_sequencer.sv
// Four-stage instruction sequencer (fetch/getRegs/readMem/writeBack) with a busy
// handshake and timeout on memory stages, plus single-level interrupt tracking.
module cpu_stage_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] instr_op,
    input  logic       busy,
    input  logic       int_req,
    output logic       fetch,
    output logic       getRegs,
    output logic       readMem,
    output logic       writeBack,
    output logic       ir_load,
    output logic       pc_advance,
    output logic       int_take,
    output logic       in_isr,
    output logic       bus_error
);
    localparam logic [3:0]       OP_RETI  = 4'h1;
    localparam logic [3:0]       OP_COPY  = 4'hC;
    localparam logic [3:0]       OP_WRITE = 4'hD;
    localparam logic [3:0]       OP_READ  = 4'hE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // One-hot encoding lets the stage outputs come straight from the state flops.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0000,
        ST_FETCH     = 4'b0001,
        ST_GETREGS   = 4'b0010,
        ST_READMEM   = 4'b0100,
        ST_WRITEBACK = 4'b1000
    } stage_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } phase_t;

    stage_t           state, state_next;
    phase_t           phase, phase_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             int_req_d;
    logic             irq_pending, irq_pending_next;
    logic             ir_load_next, pc_advance_next, int_take_next;
    logic             in_isr_next, bus_error_next;
    logic             mem_stage, handshake_done, timed_out, stage_done, irq_edge;

    assign fetch     = state[0];
    assign getRegs   = state[1];
    assign readMem   = state[2];
    assign writeBack = state[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            phase       <= PH_ISSUE;
            cnt         <= '0;
            int_req_d   <= 1'b0;
            irq_pending <= 1'b0;
            ir_load     <= 1'b0;
            pc_advance  <= 1'b0;
            int_take    <= 1'b0;
            in_isr      <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            cnt         <= cnt_next;
            int_req_d   <= int_req;
            irq_pending <= irq_pending_next;
            ir_load     <= ir_load_next;
            pc_advance  <= pc_advance_next;
            int_take    <= int_take_next;
            in_isr      <= in_isr_next;
            bus_error   <= bus_error_next;
        end
    end

    always_comb begin
        mem_stage = 1'b0;
        case (state)
            ST_FETCH:     mem_stage = 1'b1;
            ST_READMEM:   mem_stage = (instr_op == OP_READ)  || (instr_op == OP_COPY);
            ST_WRITEBACK: mem_stage = (instr_op == OP_WRITE) || (instr_op == OP_COPY);
            default:      mem_stage = 1'b0;
        endcase

        handshake_done = (phase == PH_WAIT_LO) && !busy;
        timed_out      = mem_stage && (cnt == CNT_LAST);
        stage_done     = (state != ST_IDLE) && (!mem_stage || handshake_done || timed_out);

        state_next = state;
        case (state)
            ST_IDLE:      state_next = ST_FETCH;
            ST_FETCH:     if (stage_done) state_next = ST_GETREGS;
            ST_GETREGS:   if (stage_done) state_next = ST_READMEM;
            ST_READMEM:   if (stage_done) state_next = ST_WRITEBACK;
            ST_WRITEBACK: if (stage_done) state_next = ST_FETCH;
            default:      state_next = ST_IDLE;
        endcase

        // Busy is ignored in ISSUE so a stale high from the previous access is not mistaken for a new one.
        phase_next = phase;
        if ((state == ST_IDLE) || stage_done) begin
            phase_next = PH_ISSUE;
        end else begin
            case (phase)
                PH_ISSUE:   phase_next = PH_WAIT_HI;
                PH_WAIT_HI: if (busy) phase_next = PH_WAIT_LO;
                default:    phase_next = phase;
            endcase
        end

        cnt_next = cnt;
        if ((state == ST_IDLE) || stage_done) begin
            cnt_next = '0;
        end else if (mem_stage) begin
            cnt_next = cnt + CNT_W'(1);
        end

        irq_edge         = int_req && !int_req_d;
        ir_load_next     = stage_done && (state == ST_FETCH);
        pc_advance_next  = stage_done && (state == ST_WRITEBACK);
        int_take_next    = pc_advance_next && irq_pending && !in_isr;
        irq_pending_next = (irq_pending && !int_take_next) || irq_edge;

        // A RETI retiring with a request pending leaves it for the next retirement.
        in_isr_next = in_isr;
        if (int_take_next) begin
            in_isr_next = 1'b1;
        end else if (pc_advance_next && (instr_op == OP_RETI)) begin
            in_isr_next = 1'b0;
        end

        bus_error_next = bus_error || (timed_out && !handshake_done);
    end
endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer: the driver pushes the expected stage
// lengths and retirement flags per instruction, the negedge monitor pops and compares.
module tb_cpu_stage_sequencer;
    localparam int         TIMEOUT  = 16;
    localparam int         CNT_W    = 8;
    localparam logic [3:0] OP_RETI  = 4'h1;
    localparam logic [3:0] OP_ARITH = 4'h2;
    localparam logic [3:0] OP_COPY  = 4'hC;
    localparam logic [3:0] OP_WRITE = 4'hD;
    localparam logic [3:0] OP_READ  = 4'hE;

    typedef struct {
        int   fl;
        int   gl;
        int   rl;
        int   wl;
        logic take;
        logic isr;
        logic berr;
    } exp_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] instr_op = 4'h0;
    logic       busy     = 1'b0;
    logic       int_req  = 1'b0;
    logic       fetch, getRegs, readMem, writeBack;
    logic       ir_load, pc_advance, int_take, in_isr, bus_error;

    int   test_count = 0;
    int   fail_count = 0;
    int   strobe_bad = 0;
    exp_t sb_q[$];
    logic m_pending  = 1'b0;
    logic m_isr      = 1'b0;
    logic m_berr     = 1'b0;

    int   prev_st = 0;
    int   run_len = 0;
    int   lens[5];
    int   mon_cur;
    exp_t mon_e;

    cpu_stage_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_op   (instr_op),
        .busy       (busy),
        .int_req    (int_req),
        .fetch      (fetch),
        .getRegs    (getRegs),
        .readMem    (readMem),
        .writeBack  (writeBack),
        .ir_load    (ir_load),
        .pc_advance (pc_advance),
        .int_take   (int_take),
        .in_isr     (in_isr),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int stageCode();
        if (fetch)     return 1;
        if (getRegs)   return 2;
        if (readMem)   return 3;
        if (writeBack) return 4;
        return 0;
    endfunction

    function automatic logic [8:0] outs();
        return {fetch, getRegs, readMem, writeBack, ir_load, pc_advance, int_take, in_isr, bus_error};
    endfunction

    // Busy profile: rises r cycles after stage entry and stays high h cycles (h=0: never rises).
    function automatic int memLen(input int r, input int h);
        if ((h == 0) || (r + h + 1 > TIMEOUT)) return TIMEOUT;
        return r + h + 1;
    endfunction

    function automatic logic memErr(input int r, input int h);
        return (h == 0) || (r + h + 1 > TIMEOUT);
    endfunction

    function automatic logic busyFor(input int r, input int h, input int idx);
        return (idx >= r) && (idx < r + h);
    endfunction

    // Strobes are checked every cycle; each retirement pops one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            prev_st = 0;
            run_len = 0;
        end else begin
            mon_cur = stageCode();
            if ($countones({fetch, getRegs, readMem, writeBack}) > 1) strobe_bad++;
            if (ir_load !== ((prev_st == 1) && (mon_cur == 2))) strobe_bad++;
            if (pc_advance !== ((prev_st == 4) && (mon_cur == 1))) strobe_bad++;
            if (int_take && !((prev_st == 4) && (mon_cur == 1))) strobe_bad++;
            if (mon_cur == prev_st) begin
                run_len++;
            end else begin
                lens[prev_st] = run_len;
                run_len = 1;
                if (prev_st == 4) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        mon_e = sb_q.pop_front();
                        checkOutput("fetch_len",     lens[1], mon_e.fl);
                        checkOutput("getregs_len",   lens[2], mon_e.gl);
                        checkOutput("readmem_len",   lens[3], mon_e.rl);
                        checkOutput("writeback_len", lens[4], mon_e.wl);
                        checkOutput("pc_advance",    pc_advance, 1'b1);
                        checkOutput("int_take",      int_take,  mon_e.take);
                        checkOutput("in_isr",        in_isr,    mon_e.isr);
                        checkOutput("bus_error",     bus_error, mon_e.berr);
                    end
                end
            end
            prev_st = mon_cur;
        end
    end

    // Called in the first FETCH cycle (posedge+1); returns in the first FETCH cycle of the next instruction.
    task automatic applyStimulus(input logic [3:0] op, input int fr, input int fh, input int rr, input int rh,
                                 input int wr, input int wh, input bit irq, input int abort_idx);
        exp_t e;
        int   st;
        int   pst;
        int   idx;
        bit   seen_wb;
        bit   done;
        bit   rd_mem;
        bit   wb_mem;
        bit   take;
        rd_mem   = (op == OP_READ)  || (op == OP_COPY);
        wb_mem   = (op == OP_WRITE) || (op == OP_COPY);
        instr_op = op;
        if (abort_idx < 0) begin
            e.fl   = memLen(fr, fh);
            e.gl   = 1;
            e.rl   = rd_mem ? memLen(rr, rh) : 1;
            e.wl   = wb_mem ? memLen(wr, wh) : 1;
            m_berr = m_berr | memErr(fr, fh) | (rd_mem && memErr(rr, rh)) | (wb_mem && memErr(wr, wh));
            if (irq) m_pending = 1'b1;
            take = m_pending && !m_isr;
            if (take) begin
                m_pending = 1'b0;
                m_isr     = 1'b1;
            end else if (op == OP_RETI) begin
                m_isr = 1'b0;
            end
            e.take = take;
            e.isr  = m_isr;
            e.berr = m_berr;
            sb_q.push_back(e);
        end
        idx     = 0;
        pst     = 1;
        seen_wb = 0;
        done    = 0;
        for (int cyc = 0; (cyc < 200) && !done; cyc++) begin
            st = stageCode();
            if (cyc > 0) idx = (st == pst) ? idx + 1 : 0;
            if (seen_wb && (st != 4)) begin
                done = 1;
            end else begin
                if (st == 4) seen_wb = 1;
                case (st)
                    1:       busy = busyFor(fr, fh, idx);
                    3:       busy = rd_mem && busyFor(rr, rh, idx);
                    4:       busy = wb_mem && busyFor(wr, wh, idx);
                    default: busy = 1'b0;
                endcase
                int_req = irq && (st == 2) && (idx == 0);
                if ((abort_idx >= 0) && (st == 3) && (idx == abort_idx)) begin
                    #2 reset = 1'b0;
                    busy    = 1'b0;
                    int_req = 1'b0;
                    #1 checkOutput("reset_async", outs(), 9'h000);
                    repeat (2) @(posedge clk);
                    #1 checkOutput("reset_hold", outs(), 9'h000);
                    m_pending = 1'b0;
                    m_isr     = 1'b0;
                    m_berr    = 1'b0;
                    reset     = 1'b1;
                    #1 checkOutput("idle_after_abort", outs(), 9'h000);
                    @(posedge clk);
                    #1 checkOutput("fetch_restart", {fetch, getRegs, readMem, writeBack}, 4'b1000);
                    done = 1;
                end else begin
                    pst = st;
                    @(posedge clk);
                    #1;
                end
            end
        end
        checkOutput("instr_complete", done, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_outputs", outs(), 9'h000);
        reset = 1'b1;
        #1 checkOutput("idle_after_reset", outs(), 9'h000);
        @(posedge clk);
        #1 checkOutput("fetch_after_idle", {fetch, getRegs, readMem, writeBack}, 4'b1000);

        applyStimulus(OP_ARITH, 2, 3,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_COPY,  1, 1,  1, 1,  1, 1, 1'b0, -1);
        applyStimulus(OP_READ,  1, 2,  3, 2,  0, 0, 1'b0, -1);
        applyStimulus(OP_WRITE, 1, 1,  0, 0,  2, 1, 1'b0, -1);
        applyStimulus(OP_ARITH, 1, 14, 0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_ARITH, 1, 1,  0, 0,  0, 0, 1'b1, -1);
        applyStimulus(OP_ARITH, 1, 1,  0, 0,  0, 0, 1'b1, -1);
        applyStimulus(OP_RETI,  1, 1,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_ARITH, 1, 1,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_RETI,  1, 1,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_ARITH, 1, 0,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_COPY,  1, 1,  1, 1,  1, 1, 1'b0, -1);
        applyStimulus(OP_READ,  1, 1,  1, 3,  0, 0, 1'b0, 2);
        applyStimulus(OP_ARITH, 1, 1,  0, 0,  0, 0, 1'b0, -1);
        applyStimulus(OP_READ,  1, 1,  2, 14, 0, 0, 1'b0, -1);

        @(negedge clk);
        #1;
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("strobe_timing", strobe_bad, 0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
